// File: rtl/radiant_aux_ctrl.sv
// Framed, parity-checked control receiver for the RADIANT auxiliary CPLD.
// Hunts a sync nibble, shifts in payload+parity, commits channel/mode selects and counts BIST SHOUT edges.
module radiant_aux_ctrl #(
    parameter int unsigned NUM_CH = 12,
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned ASEL_W = 3,
    parameter logic [3:0]  SYNC   = 4'hA,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned HIT_W  = 16
) (
    input  logic              CTRL_CLK,
    input  logic              CTRL_RST,
    input  logic              CTRL_EN,
    input  logic              CTRL_DATA,
    input  logic [NUM_CH-1:0] SHOUT,
    output logic [SEL_W-1:0]  SEL,
    output logic [ASEL_W-1:0] ANALOG_SEL,
    output logic              BIST,
    output logic              MT_EN,
    output logic [ERR_W-1:0]  FRAME_ERR_CNT,
    output logic [HIT_W-1:0]  HIT_CNT,
    output logic [3:0]        LED
);

    localparam int unsigned P_W   = SEL_W + ASEL_W + 2;
    localparam int unsigned F_W   = P_W + 1;
    localparam int unsigned CNT_W = $clog2(F_W + 1);

    typedef enum logic [1:0] {HUNT, SHIFT, CHECK} state_e;

    state_e              state_q, state_d;
    logic [3:0]          win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [F_W-1:0]      sr_q, sr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ASEL_W-1:0]   asel_q, asel_d;
    logic                bist_q, bist_d;
    logic                mt_q, mt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [HIT_W-1:0]    hit_q, hit_d;
    logic [3:0]          led_q, led_d;
    logic [NUM_CH-1:0]   meta_q, meta_d;
    logic [NUM_CH-1:0]   sync_q, sync_d;
    logic [NUM_CH-1:0]   prev_q, prev_d;

    logic [3:0]          win_shift;
    logic [SEL_W-1:0]    rx_sel;
    logic [ASEL_W-1:0]   rx_asel;
    logic                rx_bist;
    logic                rx_mt;
    logic [2:0]          rx_asel3;
    logic                sel_ok;
    logic [NUM_CH-1:0]   fall;
    logic                hit_sel;
    logic                commit;
    logic                err_inc;

    assign win_shift = {CTRL_DATA, win_q[3:1]};
    assign rx_sel    = sr_q[SEL_W-1:0];
    assign rx_asel   = sr_q[SEL_W +: ASEL_W];
    assign rx_bist   = sr_q[SEL_W + ASEL_W];
    assign rx_mt     = sr_q[SEL_W + ASEL_W + 1];
    assign rx_asel3  = 3'(rx_asel);
    assign sel_ok    = {1'b0, rx_sel} < (SEL_W + 1)'(NUM_CH);
    assign fall      = prev_q & ~sync_q;

    // Falling edge on the currently committed channel
    always_comb begin
        hit_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                hit_sel = fall[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        sel_d   = sel_q;
        asel_d  = asel_q;
        bist_d  = bist_q;
        mt_d    = mt_q;
        err_d   = err_q;
        hit_d   = hit_q;
        led_d   = led_q;
        meta_d  = SHOUT;
        sync_d  = meta_q;
        prev_d  = sync_q;
        commit  = 1'b0;
        err_inc = 1'b0;

        case (state_q)
            HUNT: begin
                if (CTRL_EN) begin
                    if (win_shift == SYNC) begin
                        state_d = SHIFT;
                        win_d   = 4'd0;
                        cnt_d   = '0;
                    end else begin
                        win_d = win_shift;
                    end
                end else begin
                    win_d = 4'd0;
                end
            end
            SHIFT: begin
                if (CTRL_EN) begin
                    sr_d  = {CTRL_DATA, sr_q[F_W-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(F_W - 1)) begin
                        state_d = CHECK;
                    end
                end else begin
                    err_inc = 1'b1;
                    state_d = HUNT;
                end
            end
            CHECK: begin
                state_d = HUNT;
                if (!(^sr_q) && sel_ok) begin
                    commit = 1'b1;
                end else begin
                    err_inc = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        if (commit) begin
            sel_d  = rx_sel;
            asel_d = rx_asel;
            bist_d = rx_bist;
            mt_d   = rx_mt;
            led_d  = rx_bist ? {1'b1, rx_asel3} : 4'(rx_sel);
        end

        // Commit clear beats a coincident edge; edges use the pre-commit SEL/BIST
        if (commit) begin
            hit_d = '0;
        end else if (bist_q && hit_sel && (hit_q != '1)) begin
            hit_d = hit_q + HIT_W'(1);
        end

        if (err_inc && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
        if (CTRL_RST) begin
            state_q <= HUNT;
            win_q   <= 4'd0;
            cnt_q   <= '0;
            sr_q    <= '0;
            sel_q   <= '0;
            asel_q  <= '0;
            bist_q  <= 1'b0;
            mt_q    <= 1'b0;
            err_q   <= '0;
            hit_q   <= '0;
            led_q   <= 4'd0;
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            sel_q   <= sel_d;
            asel_q  <= asel_d;
            bist_q  <= bist_d;
            mt_q    <= mt_d;
            err_q   <= err_d;
            hit_q   <= hit_d;
            led_q   <= led_d;
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
        end
    end

    assign SEL           = sel_q;
    assign ANALOG_SEL    = asel_q;
    assign BIST          = bist_q;
    assign MT_EN         = mt_q;
    assign FRAME_ERR_CNT = err_q;
    assign HIT_CNT       = hit_q;
    assign LED           = led_q;

endmodule

// File: tb/tb_radiant_aux_ctrl.sv
// Directed bench for radiant_aux_ctrl: table of frames with hand-computed results plus
// sequences for abort, SHOUT counting, error saturation and mid-frame reset.
module tb_radiant_aux_ctrl;

    localparam int unsigned NUM_CH = 12;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned ASEL_W = 3;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned HIT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              data;
    logic [NUM_CH-1:0] shout;
    logic [SEL_W-1:0]  sel;
    logic [ASEL_W-1:0] asel;
    logic              bist;
    logic              mt_en;
    logic [ERR_W-1:0]  err_cnt;
    logic [HIT_W-1:0]  hit_cnt;
    logic [3:0]        led;

    int n_vec = 0;
    int n_err = 0;

    radiant_aux_ctrl #(
        .NUM_CH(NUM_CH), .SEL_W(SEL_W), .ASEL_W(ASEL_W),
        .SYNC(4'hA), .ERR_W(ERR_W), .HIT_W(HIT_W)
    ) dut (
        .CTRL_CLK      (clk),
        .CTRL_RST      (rst),
        .CTRL_EN       (en),
        .CTRL_DATA     (data),
        .SHOUT         (shout),
        .SEL           (sel),
        .ANALOG_SEL    (asel),
        .BIST          (bist),
        .MT_EN         (mt_en),
        .FRAME_ERR_CNT (err_cnt),
        .HIT_CNT       (hit_cnt),
        .LED           (led)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] sel;
        logic [2:0] asel;
        logic       bist;
        logic       mt;
        logic       flip;
        logic [3:0] e_sel;
        logic [2:0] e_asel;
        logic       e_bist;
        logic       e_mt;
        logic [3:0] e_led;
        logic [7:0] e_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input int unsigned s, input int unsigned a,
                            input int unsigned b, input int unsigned m, input int unsigned l,
                            input int unsigned e, input int unsigned h);
        chk({tag, ".sel"},  32'(sel),     s);
        chk({tag, ".asel"}, 32'(asel),    a);
        chk({tag, ".bist"}, 32'(bist),    b);
        chk({tag, ".mt"},   32'(mt_en),   m);
        chk({tag, ".led"},  32'(led),     l);
        chk({tag, ".err"},  32'(err_cnt), e);
        chk({tag, ".hit"},  32'(hit_cnt), h);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        en   = 1'b1;
        data = b;
    endtask

    // Sync, payload LSB first, parity; returns at the first negedge where outputs are valid
    task automatic send_frame(input logic [3:0] s, input logic [2:0] a, input logic b,
                              input logic m, input logic flip, input logic drop5);
        logic [8:0] p;
        p = {m, b, a, s};
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 9; i++) begin
            send_bit(p[i]);
            if (drop5 && i == 8) shout[5] = 1'b0;
        end
        send_bit((^p) ^ flip);
        @(negedge clk);
        en   = 1'b0;
        data = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse(input int ch);
        @(negedge clk);
        shout[ch] = 1'b1;
        repeat (3) @(negedge clk);
        shout[ch] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{4'd5,  3'd3, 1'b1, 1'b0, 1'b1, 4'd0,  3'd0, 1'b0, 1'b0, 4'h0, 8'd1};
        vecs[1] = '{4'd5,  3'd3, 1'b1, 1'b0, 1'b0, 4'd5,  3'd3, 1'b1, 1'b0, 4'hB, 8'd1};
        vecs[2] = '{4'd13, 3'd3, 1'b1, 1'b0, 1'b0, 4'd5,  3'd3, 1'b1, 1'b0, 4'hB, 8'd2};
        vecs[3] = '{4'd11, 3'd7, 1'b0, 1'b1, 1'b0, 4'd11, 3'd7, 1'b0, 1'b1, 4'hB, 8'd2};
        vecs[4] = '{4'd0,  3'd0, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b0, 4'h0, 8'd2};
        vecs[5] = '{4'd12, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b0, 4'h0, 8'd3};
        vecs[6] = '{4'd2,  3'd6, 1'b1, 1'b1, 1'b0, 4'd2,  3'd6, 1'b1, 1'b1, 4'hE, 8'd3};
        vecs[7] = '{4'd15, 3'd1, 1'b0, 1'b1, 1'b1, 4'd2,  3'd6, 1'b1, 1'b1, 4'hE, 8'd4};
        vecs[8] = '{4'd11, 3'd0, 1'b0, 1'b0, 1'b0, 4'd11, 3'd0, 1'b0, 1'b0, 4'hB, 8'd4};

        rst   = 1'b1;
        en    = 1'b0;
        data  = 1'b0;
        shout = '0;
        repeat (3) @(negedge clk);
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].sel, vecs[i].asel, vecs[i].bist, vecs[i].mt, vecs[i].flip, 1'b0);
            chk_outs($sformatf("vec%0d", i), 32'(vecs[i].e_sel), 32'(vecs[i].e_asel),
                     32'(vecs[i].e_bist), 32'(vecs[i].e_mt), 32'(vecs[i].e_led),
                     32'(vecs[i].e_err), 0);
        end

        // Abort after 5 payload bits, then junk and a clean frame
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk_outs("abort", 11, 0, 0, 0, 4'hB, 5, 0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_frame(4'd5, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_outs("rehunt", 5, 3, 1, 0, 4'hB, 5, 0);

        // Three edges on the selected channel, five on a neighbour
        for (int i = 0; i < 5; i++) begin
            pulse(4);
            if (i < 3) pulse(5);
        end
        repeat (4) @(negedge clk);
        chk("shout_hits", 32'(hit_cnt), 3);

        // Commit coincident with a falling edge on SHOUT[5]
        shout[5] = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(4'd5, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_outs("commit_clr", 5, 3, 1, 0, 4'hB, 5, 0);
        repeat (4) @(negedge clk);
        chk("commit_clr_late", 32'(hit_cnt), 0);

        // No counting with BIST=0
        send_frame(4'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(5);
        pulse(5);
        repeat (4) @(negedge clk);
        chk_outs("bist_off", 5, 3, 0, 0, 4'h5, 5, 0);

        for (int i = 0; i < 300; i++) begin
            send_frame(4'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk_outs("err_sat", 5, 3, 0, 0, 4'h5, 255, 0);

        // Reset in the middle of a payload
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(4'd5, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_outs("post_rst", 5, 3, 1, 0, 4'hB, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/radiant_aux_ctrl.md
Name: radiant_aux_ctrl

Overview:
- Framed, parity-checked control receiver for the RADIANT auxiliary CPLD.
- Replaces the free-running 8-bit control shift register with a sync-hunted serial frame.
- Drives monitor channel select, analog/BIST select and the BIST/MONTIMING mode flags for NUM_CH LAB4 channels.
- Adds frame-error accounting and a BIST SHOUT edge counter on the selected channel.

Parameters:
- NUM_CH, 12: number of LAB4 channels; legal select values are 0..NUM_CH-1.
- SEL_W, 4: width of channel select; must satisfy 2^SEL_W >= NUM_CH.
- ASEL_W, 3: width of the analog/debug select field.
- SYNC, 4'hA: sync nibble, sent LSB first.
- ERR_W, 8: width of the frame error counter.
- HIT_W, 16: width of the SHOUT hit counter.

Ports:
- CTRL_CLK  in  1  free-running control clock; all logic is on its rising edge.
- CTRL_RST  in  1  asynchronous, active-high reset.
- CTRL_EN  in  1  frame enable; a CTRL_DATA bit is consumed only on cycles where CTRL_EN=1.
- CTRL_DATA  in  1  serial frame data, LSB first.
- SHOUT  in  NUM_CH  per-channel SHOUT/SS_INCR readback; asynchronous to CTRL_CLK.
- SEL  out  SEL_W  committed channel select.
- ANALOG_SEL  out  ASEL_W  committed analog/debug select.
- BIST  out  1  committed BIST mode flag.
- MT_EN  out  1  committed MONTIMING output enable.
- FRAME_ERR_CNT  out  ERR_W  saturating count of rejected or aborted frames.
- HIT_CNT  out  HIT_W  saturating count of SHOUT falling edges on channel SEL while BIST=1.
- LED  out  4  status display.

Behaviour:

Frame format:
- Frame = SYNC (4 bits), then payload P = {MT_EN, BIST, ANALOG_SEL, SEL}, then 1 parity bit.
- Payload is sent SEL[0] first.
- P = SEL_W+ASEL_W+2 bits; 9 with default parameters.
- Parity is even: the XOR of all payload bits and the parity bit must equal 0.

Reset:
- All outputs go to 0.
- The FSM goes to HUNT.
- The sync window, bit counter and shift register are cleared.

FSM states HUNT, SHIFT, CHECK:
- HUNT:
  - On each CTRL_EN=1 cycle, shift CTRL_DATA into a 4-bit window.
  - When the window equals SYNC, go to SHIFT with the bit count at 0 and the window cleared. Sync bits are never reused.
  - CTRL_EN=0 clears the window.
- SHIFT:
  - On each CTRL_EN=1 cycle, capture one bit.
  - After P+1 bits (payload plus parity), go to CHECK.
  - CTRL_EN=0 mid-frame is an abort: FRAME_ERR_CNT +1, back to HUNT, outputs unchanged.
- CHECK (one cycle, CTRL_EN ignored):
  - Commit when parity is good and the received SEL < NUM_CH. SEL, ANALOG_SEL, BIST and MT_EN update together at the end of this cycle, and HIT_CNT clears.
  - Otherwise FRAME_ERR_CNT +1 and the outputs hold.
  - Always return to HUNT.

Latency:
- Parity bit sampled on edge N; outputs valid after edge N+1.
- The next frame's sync may start on edge N+2.

SHOUT counting:
- Each SHOUT bit passes through a 2-FF synchronizer, then a falling-edge detector on the synchronized copy.
- HIT_CNT +1 when BIST=1 and the selected channel SHOUT[SEL] falls; it saturates at all-ones.
- If a commit and an edge occur in the same cycle, the commit's clear wins and that edge is not counted.
- An edge arriving in the cycle SEL changes is attributed to the old SEL.

Error counter:
- FRAME_ERR_CNT saturates at all-ones.
- It is cleared only by CTRL_RST.

LED (registered, updates with the outputs):
- BIST=1: LED = {1, ANALOG_SEL[2:0]} (zero-extended if ASEL_W < 3).
- BIST=0: LED = SEL[3:0], zero-extended when SEL_W < 4.

Reset mid-frame:
- Immediate return to HUNT and all outputs 0, regardless of the current state.

Test Plan:
1. Valid frame:
   - Stimulus: after reset, CTRL_EN=1, send sync bits 0,1,0,1, then payload SEL=5, ANALOG_SEL=3, BIST=1, MT_EN=0, i.e. bits 1,0,1,0,1,1,0,1,0, then parity 1.
   - Response: one cycle after the parity bit, SEL=5, ANALOG_SEL=3, BIST=1, MT_EN=0, LED=4'hB, FRAME_ERR_CNT=0.
2. Bad parity:
   - Stimulus: the same frame with parity 0.
   - Response: outputs stay at reset values (0), FRAME_ERR_CNT=1.
3. Out-of-range select:
   - Stimulus: SEL=13 with correct parity, NUM_CH=12.
   - Response: outputs unchanged, FRAME_ERR_CNT increments by 1.
4. Abort and re-hunt:
   - Stimulus: drop CTRL_EN after 5 payload bits, then resend test 1's frame preceded by junk 1,1,0.
   - Response: FRAME_ERR_CNT +1 on the abort, then a clean commit of SEL=5.
5. SHOUT counting:
   - Stimulus: BIST=1, SEL=5; toggle SHOUT[5] 3 times (3 falling edges) and SHOUT[4] 10 times.
   - Response: HIT_CNT=3 at least 3 cycles after the last edge. A further valid commit clears HIT_CNT to 0, even with a coincident edge.
6. Saturation and asynchronous reset:
   - Stimulus: 300 bad frames with ERR_W=8, then assert CTRL_RST mid-frame.
   - Response: FRAME_ERR_CNT holds at 255, then all outputs are 0 immediately on reset. The next valid frame commits normally.
